// File: rtl/lsu_pkg.sv
// Shared types and load-control encodings for the data-side memory stage.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

endpackage

// File: rtl/lsu_bus_unit_load_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  load_ctrl,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  // Unknown encodings fall back to the whole word rather than trapping.
  always_comb begin
    result = word;
    case (load_ctrl)
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'h0, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'h0, half_sel};
      LD_LW:   result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_bus_unit.sv
// Data-side memory stage: runs a req/gnt/rvalid bus access, stalls the core
// until it completes, and aborts with bus_err if the bus stops responding.
module lsu_bus_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_mem,
  input  logic [3:0]  mask,
  input  logic [2:0]  load_ctrl,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        done,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off;
  logic [2:0]       ld_ctrl;
  logic [31:0]      aligned;
  logic             accept, complete, expire;

  load_align u_align (
    .word      (bus_rdata),
    .off       (off),
    .load_ctrl (ld_ctrl),
    .result    (aligned)
  );

  // A genuine completion in the final counted cycle beats the timeout.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    bus_req    = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        stall  = mem_rd | mem_wr;
        accept = mem_rd | mem_wr;
        if (accept) next_state = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        if (bus_gnt) begin
          if (bus_we) begin
            complete   = 1'b1;
            next_state = DONE;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          complete   = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if ((state == REQ || state == WAIT) && cnt == CNT_LAST && !complete) begin
      expire     = 1'b1;
      next_state = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      off       <= 2'd0;
      ld_ctrl   <= 3'd0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_be    <= 4'h0;
      rdata_out <= 32'h0;
      bus_err   <= 1'b0;
    end else begin
      state   <= next_state;
      bus_err <= expire;
      if (accept) begin
        bus_addr  <= {addr[31:2], 2'b00};
        off       <= addr[1:0];
        bus_wdata <= wdata_mem;
        ld_ctrl   <= load_ctrl;
        bus_we    <= mem_wr;
        bus_be    <= mem_wr ? mask : 4'hF;
        cnt       <= '0;
      end else if (state == REQ || state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (expire) begin
        rdata_out <= 32'h0;
      end else if (state == WAIT && bus_rvalid) begin
        rdata_out <= aligned;
      end
    end
  end

endmodule
